ram_fifo_ctrl: RTL and testbench

//   Single-clock synchronous FIFO. Internal 2-port memory: write side (port A role), read side (port B role).

---
 rtl/ram_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - single-clock RAM-backed FIFO with sticky overflow/underflow flags
//
// Purpose:
//   A synchronous FIFO built on a 2-port memory. The write side (port A role) stores wr_data
//   at wr_ptr. The read side (port B role) registers mem[rd_ptr] into rd_data one cycle after
//   an accepted pop. All status flags are decoded from the registered occupancy count, so a
//   request in the same cycle never changes a flag.
//
// Ports:
//   clock         single clock, rising edge
//   reset         asynchronous, active-high
//   wr_data       word to push
//   wr_en         push request; accepted when !full
//   full          count == DEPTH
//   rd_en         pop request; accepted when !empty
//   rd_data       popped word, registered, holds when idle
//   rd_valid      rd_data carries a word popped on the previous edge
//   empty         count == 0
//   count         occupancy, 0..DEPTH
//   overflow      sticky: wr_en seen while full
//   underflow     sticky: rd_en seen while empty
//   almost_full   count >= AF_LEVEL   (only with RAM_FIFO_ALMOST_EN)
//   almost_empty  count <= AE_LEVEL   (only with RAM_FIFO_ALMOST_EN)
//
// Build option:
//   RAM_FIFO_ALMOST_EN  adds the almost_full / almost_empty outputs.

module ram_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
`ifdef RAM_FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  // Thresholds above DEPTH would leave a flag permanently asserted or never asserted.
  if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_level_check
    $error("ram_fifo_ctrl: AF_LEVEL/AE_LEVEL must not exceed DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // Requests are qualified by the registered flags only; a pop in the same cycle does not
  // make room for a push into a full FIFO, and vice versa for an empty one.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // Memory has no reset so it maps onto plain RAM. A push and a pop can only hit the same
  // address when count is 0 or DEPTH, and in both cases one of them is rejected, so there
  // is never a read-during-write collision.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= pop;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef RAM_FIFO_ALMOST_EN
  localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT = (ADDR_W + 1)'(AE_LEVEL);

  // Count resets to 0, which yields almost_full = 0 and almost_empty = 1 during reset.
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - directed self-checking bench for ram_fifo_ctrl

module tb_ram_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       full;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;
`ifdef RAM_FIFO_ALMOST_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  ram_fifo_ctrl #(
    .DATA_W  (8),
    .ADDR_W  (6),
    .AF_LEVEL(56),
    .AE_LEVEL(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef RAM_FIFO_ALMOST_EN
    ,
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++;
    if (count !== 7'd0) $display("FAIL reset_count got %0d want 0", count);
    else n_pass++;
    n_checks++;
    if ({empty, full} !== 2'b10) $display("FAIL reset_empty_full got %b want 10", {empty, full});
    else n_pass++;
    n_checks++;
    if ({rd_valid, rd_data} !== 9'h000) $display("FAIL reset_rd got %h want 000", {rd_valid, rd_data});
    else n_pass++;
    n_checks++;
    if ({overflow, underflow} !== 2'b00) $display("FAIL reset_sticky got %b want 00", {overflow, underflow});
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals = '{8'h33, 8'h44, 8'h55};
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = vals[i];
      tick();
    end
    wr_en = 1'b0;
    n_checks++;
    if (count !== 7'd3) $display("FAIL basic_count got %0d want 3", count);
    else n_pass++;
    n_checks++;
    if (empty !== 1'b0) $display("FAIL basic_not_empty got %b want 0", empty);
    else n_pass++;
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({rd_valid, rd_data} !== {1'b1, vals[i]})
        $display("FAIL basic_pop%0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, vals[i]);
      else n_pass++;
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if ({empty, rd_valid, rd_data} !== {1'b1, 1'b0, 8'h55})
      $display("FAIL basic_idle got e=%b v=%b d=%h want e=1 v=0 d=55", empty, rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_data = 8'(i);
      tick();
    end
    n_checks++;
    if ({full, count, overflow} !== {1'b1, 7'd64, 1'b0})
      $display("FAIL full_reach got f=%b c=%0d o=%b want f=1 c=64 o=0", full, count, overflow);
    else n_pass++;
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if ({full, count, overflow} !== {1'b1, 7'd64, 1'b1})
      $display("FAIL full_overflow got f=%b c=%0d o=%b want f=1 c=64 o=1", full, count, overflow);
    else n_pass++;
    rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      n_checks++;
      if ({rd_valid, rd_data} !== {1'b1, 8'(i)})
        $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, 8'(i));
      else n_pass++;
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if ({empty, rd_valid, count} !== {1'b1, 1'b0, 7'd0})
      $display("FAIL full_drained got e=%b v=%b c=%0d want e=1 v=0 c=0", empty, rd_valid, count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic [7:0] exp;
    int n_push = 0;
    int n_pop = 0;
    logic wr;
    logic rd;
    do_reset();
    for (int c = 0; c < 500 && n_pop < 100; c++) begin
      wr = (n_push < 100) && (q.size() < 4);
      rd = (q.size() >= 1) && ((c % 3) != 0 || n_push == 100);
      wr_en   = wr;
      rd_en   = rd;
      wr_data = 8'(n_push);
      tick();
      if (rd) begin
        exp = q.pop_front();
        n_pop++;
        n_checks++;
        if ({rd_valid, rd_data} !== {1'b1, exp})
          $display("FAIL wrap_pop%0d got v=%b d=%h want v=1 d=%h", n_pop, rd_valid, rd_data, exp);
        else n_pass++;
      end
      if (wr) begin
        q.push_back(8'(n_push));
        n_push++;
      end
      n_checks++;
      if (count !== 7'(q.size())) $display("FAIL wrap_count got %0d want %0d", count, q.size());
      else n_pass++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (n_pop !== 100) $display("FAIL wrap_done got %0d pops want 100", n_pop);
    else n_pass++;
    tick();
    n_checks++;
    if ({empty, overflow, underflow} !== 3'b100)
      $display("FAIL wrap_flags got e=%b o=%b u=%b want 1 0 0", empty, overflow, underflow);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h10 + i);
      tick();
    end
    n_checks++;
    if (count !== 7'd5) $display("FAIL sim_count5 got %0d want 5", count);
    else n_pass++;
    rd_en   = 1'b1;
    wr_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({rd_valid, rd_data, count} !== {1'b1, 8'(8'h10 + i), 7'd5})
        $display("FAIL sim_both%0d got v=%b d=%h c=%0d want v=1 d=%h c=5", i, rd_valid, rd_data, count, 8'(8'h10 + i));
      else n_pass++;
    end
    rd_en = 1'b0;
    for (int i = 0; i < 59; i++) begin
      wr_data = 8'(8'h20 + i);
      tick();
    end
    wr_en = 1'b0;
    n_checks++;
    if ({full, count, overflow} !== {1'b1, 7'd64, 1'b0})
      $display("FAIL sim_fill got f=%b c=%0d o=%b want f=1 c=64 o=0", full, count, overflow);
    else n_pass++;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if ({rd_valid, rd_data, count, overflow} !== {1'b1, 8'h14, 7'd63, 1'b1})
      $display("FAIL sim_full_both got v=%b d=%h c=%0d o=%b want v=1 d=14 c=63 o=1", rd_valid, rd_data, count, overflow);
    else n_pass++;
    rd_en = 1'b1;
    for (int i = 0; i < 63; i++) begin
      tick();
      exp = (i < 4) ? 8'h77 : 8'(8'h20 + i - 4);
      n_checks++;
      if ({rd_valid, rd_data} !== {1'b1, exp})
        $display("FAIL sim_drain%0d got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
      else n_pass++;
    end
    rd_en = 1'b0;
    n_checks++;
    if ({empty, underflow} !== 2'b10) $display("FAIL sim_drained got e=%b u=%b want 1 0", empty, underflow);
    else n_pass++;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if ({rd_valid, count, underflow} !== {1'b0, 7'd1, 1'b1})
      $display("FAIL sim_empty_both got v=%b c=%0d u=%b want v=0 c=1 u=1", rd_valid, count, underflow);
    else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({rd_valid, rd_data, count} !== {1'b1, 8'h5A, 7'd0})
      $display("FAIL sim_empty_pop got v=%b d=%h c=%0d want v=1 d=5a c=0", rd_valid, rd_data, count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'hC0 + i);
      tick();
    end
    rd_en   = 1'b1;
    wr_data = 8'hCA;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if ({rd_valid, rd_data, count} !== {1'b1, 8'hC0, 7'd10})
      $display("FAIL mid_before got v=%b d=%h c=%0d want v=1 d=c0 c=10", rd_valid, rd_data, count);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({count, empty, rd_valid, rd_data} !== {7'd0, 1'b1, 1'b0, 8'h00})
      $display("FAIL mid_async got c=%0d e=%b v=%b d=%h want c=0 e=1 v=0 d=00", count, empty, rd_valid, rd_data);
    else n_pass++;
    tick();
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({rd_valid, rd_data, empty} !== {1'b1, 8'h99, 1'b1})
      $display("FAIL mid_after got v=%b d=%h e=%b want v=1 d=99 e=1", rd_valid, rd_data, empty);
    else n_pass++;
  endtask

`ifdef RAM_FIFO_ALMOST_EN
  task automatic test_almost();
    do_reset();
    for (int n = 0; n <= 64; n++) begin
      n_checks++;
      if ({almost_empty, almost_full} !== {1'(n <= 8), 1'(n >= 56)})
        $display("FAIL almost_n%0d got ae=%b af=%b want ae=%b af=%b", n, almost_empty, almost_full, n <= 8, n >= 56);
      else n_pass++;
      if (n < 64) begin
        wr_en   = 1'b1;
        wr_data = 8'(n);
        tick();
        wr_en = 1'b0;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
`ifdef RAM_FIFO_ALMOST_EN
    test_almost();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
